uart_rx_buffered: RTL and testbench
===================================

# uart_rx_buffered

Standalone 16x-oversampled UART receiver with a receive FIFO, the receiving end of the team's UART transmit path. Deserialises start/data/optional-parity/stop frames from `rx_in` and pushes good bytes into a small first-word-fall-through FIFO read by the host-side logic. Frame, parity and overrun errors are flagged as sticky bits. Everything runs on `rxclk` at 16x the baud rate.

## Interface
- `DATA_BITS`, 8: data bits per frame, 5..8, sent LSB first.
- `PARITY_EN`, 0: 1 = one parity bit follows the data bits.
- `PARITY_ODD`, 0: 1 = odd parity, 0 = even parity. Ignored when `PARITY_EN`=0.
- `FIFO_DEPTH`, 4: FIFO entries. Power of two, at least 2.
- `rxclk`  in  1  sampling clock, 16x baud.
- `reset`  in  1  asynchronous, active-high.
- `rx_enable`  in  1  receiver enable.
- `rx_in`  in  1  asynchronous serial line, idle high.
- `rd_en`  in  1  pop the FIFO head.
- `rd_data`  out  DATA_BITS  FIFO head. Valid only while `rd_valid`=1.
- `rd_valid`  out  1  FIFO is non-empty.
- `fifo_count`  out  clog2(FIFO_DEPTH)+1  number of occupied entries.
- `clr_err`  in  1  clears all sticky error flags.
- `frame_err`  out  1  sticky: a stop bit was sampled low.
- `parity_err`  out  1  sticky: a parity mismatch occurred.
- `overrun`  out  1  sticky: a good byte arrived while the FIFO was full.

## Operation
- **Synchroniser.** `rx_in` passes through two flops that reset to 1. The FSM uses only the synchronised bit `rxs`.
- **Counters.** `os_cnt` is a 4-bit oversample counter. `bit_cnt` counts data bits.
- **FSM states:** IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: when `rxs`=0, go to START and set `os_cnt`=0.
  - START: increment `os_cnt`. At `os_cnt`=7:
    - if `rxs`=1, it was a glitch; return to IDLE;
    - otherwise go to DATA with `os_cnt`=0 and `bit_cnt`=0.
  - DATA: increment `os_cnt`. At `os_cnt`=15, sample `rxs` into shift-register bit `bit_cnt`. After DATA_BITS samples, go to PARITY if `PARITY_EN`=1, else STOP.
  - PARITY: at `os_cnt`=15, compare `rxs` with the expected parity. Record a mismatch internally. Then go to STOP.
  - STOP: at `os_cnt`=15, resolve the frame:
    - `rxs`=0: set `frame_err`, discard the byte, go to WAIT_HIGH;
    - `rxs`=1 and parity mismatch: set `parity_err`, discard the byte, go to IDLE;
    - otherwise the byte is good: push it if the FIFO is not full, else set `overrun` and drop it; go to IDLE.
  - WAIT_HIGH: stay until `rxs`=1, then go to IDLE. This prevents a break condition from retriggering reception.
- **Receiver disable.** `rx_enable`=0 forces the FSM to IDLE on the next edge. FIFO contents and error flags are kept.
- **FIFO.**
  - `rd_en` with `rd_valid`=0 is ignored.
  - Push and pop in the same cycle are both performed, including when the FIFO is full. That case is not an overrun.
  - Pointers wrap modulo FIFO_DEPTH.
- **Error flags.** `clr_err` clears all three flags. If `clr_err` and a new error occur in the same cycle, the set wins.
- **Reset values.**
  - FSM in IDLE, both synchroniser flops = 1.
  - FIFO empty: `rd_valid`=0, `fifo_count`=0, `rd_data`=0.
  - All error flags = 0.
  - Reset mid-frame abandons the frame; no partial byte is pushed.

## Timing
- Let T be the `rxclk` edge on which the FSM enters START. `rx_in` is low at the line at least 2 edges before T.
- Start bit is validated at T+8.
- Data bit i (0-based) is sampled at T+8+16(i+1).
- Parity bit, if present, is sampled at T+8+16(DATA_BITS+1).
- Stop bit is sampled at T+8+16(DATA_BITS+1+PARITY_EN). The push happens on that same edge, so `rd_valid` and `fifo_count` update right after it. For 8N1 the push edge is T+152.
- Pop: `rd_data` shows the next entry on the edge after `rd_en`. `fifo_count` changes on that same edge.
- Error flags assert on the edge that resolves the stop bit.

## Structure
- Package `uart_pkg` holds:
  - the FSM state enum;
  - `OVERSAMPLE`=16;
  - `MID_START`=7, `MID_BIT`=15;
  - a parity helper function.
- Sub-module `uart_rx_fifo` is a parameterised synchronous FWFT FIFO with ports push/pop/data/count/full/empty. It is reused on the TX side later.
- The top level holds the synchroniser, FSM, counters and error flags, about 200 lines.

## Test plan
- **Good 8N1 frame.** Send 0xA5 with 16 `rxclk` per bit. Required: at T+152, `rd_valid`=1, `rd_data`=0xA5, `fifo_count`=1, no errors.
- **Glitch rejection.** Drive `rx_in` low for 4 `rxclk`, then high. Required: FSM returns to IDLE, nothing is pushed.
- **Framing error.** Send 0x3C with stop bit low, followed by 40 low cycles, then idle, then 0x11. Required: `frame_err`=1, only 0x11 is in the FIFO. `clr_err` then clears `frame_err`.
- **Parity.** With `PARITY_EN`=1, `PARITY_ODD`=0, send 0x07 with parity bit 0. Required: `parity_err`=1, FIFO stays empty. 0x07 with parity bit 1 is accepted.
- **Overrun.** With DEPTH=4, send 5 bytes 0x01..0x05 with no reads. Required: `overrun`=1, `fifo_count`=4, pops return 0x01..0x04.
- **Simultaneous push/pop and reset.**
  - FIFO full: assert `rd_en` on the push edge of 0x55. Required: no overrun, count stays 4.
  - Assert `reset` mid-frame. Required: empty FIFO, flags 0, next frame received cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART receive path: receiver FSM state encoding,
// oversampling constants and a parity helper.
// No ports (package).

package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_e;

    localparam int         OVERSAMPLE = 16;
    localparam logic [3:0] MID_START  = 4'd7;
    localparam logic [3:0] MID_BIT    = 4'd15;

    // Parity bit a transmitter would append to the low nbits of data.
    // Even parity: XOR of the data bits. Odd parity: its complement.
    function automatic logic parity_bit(input logic [7:0] data,
                                        input int         nbits,
                                        input logic       odd);
        logic p;
        p = odd;
        for (int i = 0; i < 8; i++) begin
            if (i < nbits) begin
                p = p ^ data[i];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Synchronous first-word-fall-through FIFO. The head entry is always
// presented on pop_data; pop advances to the next entry on the following
// edge. Push while full is ignored unless a pop happens in the same cycle.
// Pop while empty is ignored.
// Ports:
//   clk        in   clock
//   reset      in   asynchronous, active-high
//   push       in   write push_data at the tail
//   push_data  in   WIDTH  data to write
//   pop        in   drop the head entry
//   pop_data   out  WIDTH  head entry (zero after reset)
//   count      out  clog2(DEPTH)+1  occupied entries
//   full       out  count == DEPTH
//   empty      out  count == 0

module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    assign do_pop  = pop && !empty;
    // When full, a simultaneous pop frees the slot being written.
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered
// 16x-oversampled UART receiver feeding a FWFT receive FIFO, with sticky
// frame / parity / overrun error flags.
// Ports:
//   rxclk       in   sampling clock, 16x baud
//   reset       in   asynchronous, active-high
//   rx_enable   in   receiver enable; low forces the FSM idle
//   rx_in       in   asynchronous serial line, idle high
//   rd_en       in   pop FIFO head
//   rd_data     out  DATA_BITS  FIFO head, valid while rd_valid
//   rd_valid    out  FIFO non-empty
//   fifo_count  out  clog2(FIFO_DEPTH)+1  occupied entries
//   clr_err     in   clear sticky error flags (a same-cycle set wins)
//   frame_err   out  sticky: stop bit sampled low
//   parity_err  out  sticky: parity mismatch
//   overrun     out  sticky: good byte arrived with FIFO full
//
// state      | meaning
// -----------+--------------------------------------------------------
// IDLE       | line idle, waiting for a low rxs
// START      | counting to mid start bit, rejecting glitches
// DATA       | sampling data bits at end of each 16-clock bit period
// PARITY     | sampling parity bit, recording any mismatch
// STOP       | sampling stop bit, resolving the frame
// WAIT_HIGH  | after a framing error, wait for the line to return high

module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          rxclk,
    input  logic                          reset,
    input  logic                          rx_enable,
    input  logic                          rx_in,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    input  logic                          clr_err,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic       sync1_q, sync1_d;
    logic       rxs_q, rxs_d;
    rx_state_e  state_q, state_d;
    logic [3:0] os_cnt_q, os_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       par_bad_q, par_bad_d;
    logic       frame_err_q, frame_err_d;
    logic       parity_err_q, parity_err_d;
    logic       overrun_q, overrun_d;

    logic       push;
    logic       set_frame, set_parity, set_overrun;
    logic       fifo_full, fifo_empty;

    assign sync1_d = rx_in;
    assign rxs_d   = sync1_q;

    always_comb begin
        state_d     = state_q;
        os_cnt_d    = os_cnt_q + 4'd1;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_bad_d   = par_bad_q;
        push        = 1'b0;
        set_frame   = 1'b0;
        set_parity  = 1'b0;
        set_overrun = 1'b0;

        case (state_q)
            ST_IDLE: begin
                os_cnt_d = '0;
                if (!rxs_q) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (os_cnt_q == MID_START) begin
                    if (rxs_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_DATA;
                        os_cnt_d  = '0;
                        bit_cnt_d = '0;
                        par_bad_d = 1'b0;
                    end
                end
            end
            ST_DATA: begin
                // os_cnt wraps 15 -> 0 on its own, so each bit period is 16 clocks.
                if (os_cnt_q == MID_BIT) begin
                    shift_d[bit_cnt_q] = rxs_q;
                    bit_cnt_d          = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (os_cnt_q == MID_BIT) begin
                    par_bad_d = (rxs_q != parity_bit(shift_q, DATA_BITS, PARITY_ODD != 0));
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (os_cnt_q == MID_BIT) begin
                    if (!rxs_q) begin
                        set_frame = 1'b1;
                        state_d   = ST_WAIT_HIGH;
                    end else if (par_bad_q) begin
                        set_parity = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        // A pop on this edge makes room, so full alone is not an overrun.
                        if (fifo_full && !rd_en) begin
                            set_overrun = 1'b1;
                        end else begin
                            push = 1'b1;
                        end
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                if (rxs_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!rx_enable) begin
            state_d     = ST_IDLE;
            push        = 1'b0;
            set_frame   = 1'b0;
            set_parity  = 1'b0;
            set_overrun = 1'b0;
        end
    end

    assign frame_err_d  = (frame_err_q  && !clr_err) || set_frame;
    assign parity_err_d = (parity_err_q && !clr_err) || set_parity;
    assign overrun_d    = (overrun_q    && !clr_err) || set_overrun;

    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            sync1_q      <= 1'b1;
            rxs_q        <= 1'b1;
            state_q      <= ST_IDLE;
            os_cnt_q     <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_bad_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            rxs_q        <= rxs_d;
            state_q      <= state_d;
            os_cnt_q     <= os_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_bad_q    <= par_bad_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (rxclk),
        .reset     (reset),
        .push      (push),
        .push_data (shift_q[DATA_BITS-1:0]),
        .pop       (rd_en),
        .pop_data  (rd_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rd_valid   = !fifo_empty;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_buffered.sv
module tb_uart_rx_buffered;

    logic       rxclk = 1'b0;
    logic       reset;
    logic       rx_enable;
    logic       rx_a, rx_b;
    logic       rd_en, rd_en_p;
    logic       clr_err;

    logic [7:0] rd_data, rd_data_p;
    logic       rd_valid, rd_valid_p;
    logic [2:0] fifo_count, fifo_count_p;
    logic       frame_err, parity_err, overrun;
    logic       frame_err_p, parity_err_p, overrun_p;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 rxclk = ~rxclk;

    uart_rx_buffered #(
        .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .FIFO_DEPTH(4)
    ) dut (
        .rxclk(rxclk), .reset(reset), .rx_enable(rx_enable), .rx_in(rx_a),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .fifo_count(fifo_count), .clr_err(clr_err), .frame_err(frame_err),
        .parity_err(parity_err), .overrun(overrun)
    );

    uart_rx_buffered #(
        .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .FIFO_DEPTH(4)
    ) dut_p (
        .rxclk(rxclk), .reset(reset), .rx_enable(rx_enable), .rx_in(rx_b),
        .rd_en(rd_en_p), .rd_data(rd_data_p), .rd_valid(rd_valid_p),
        .fifo_count(fifo_count_p), .clr_err(clr_err), .frame_err(frame_err_p),
        .parity_err(parity_err_p), .overrun(overrun_p)
    );

    task automatic tick();
        @(posedge rxclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_line(input int tgt, input logic v);
        if (tgt == 0) rx_a = v;
        else          rx_b = v;
    endtask

    task automatic pop_main();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    // Line goes low just after edge P0; stop bit is sampled (and any push
    // happens) 11 edges into the stop-bit window, i.e. T+8+16*(9+par).
    task automatic send_frame(input int tgt, input logic [7:0] d, input logic has_par,
                              input logic par_bit, input logic stop_bit, input int tail_low,
                              input bit chk_push, input bit pop_on_push);
        tick();
        set_line(tgt, 1'b0);
        repeat (16) tick();
        for (int i = 0; i < 8; i++) begin
            set_line(tgt, d[i]);
            repeat (16) tick();
        end
        if (has_par) begin
            set_line(tgt, par_bit);
            repeat (16) tick();
        end
        set_line(tgt, stop_bit);
        repeat (10) tick();
        if (chk_push) check("valid_before_push_edge", rd_valid, 1'b0);
        if (pop_on_push) rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        if (chk_push) begin
            check("valid_at_push_edge", rd_valid, 1'b1);
            check("data_at_push_edge", rd_data, 8'hA5);
            check("count_at_push_edge", fifo_count, 3'd1);
            check("no_err_after_good", {frame_err, parity_err, overrun}, 3'b000);
        end
        repeat (5) tick();
        if (tail_low > 0) begin
            set_line(tgt, 1'b0);
            repeat (tail_low) tick();
        end
        set_line(tgt, 1'b1);
        repeat (20) tick();
    endtask

    initial begin
        reset = 1'b1; rx_enable = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
        rd_en = 1'b0; rd_en_p = 1'b0; clr_err = 1'b0;
        repeat (3) tick();
        check("reset_valid", rd_valid, 1'b0);
        check("reset_count", fifo_count, 3'd0);
        check("reset_data", rd_data, 8'h00);
        check("reset_flags", {frame_err, parity_err, overrun}, 3'b000);
        reset = 1'b0;
        repeat (5) tick();

        // Good 8N1 frame with exact push-edge timing
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0);
        pop_main();
        check("pop_to_empty_valid", rd_valid, 1'b0);
        check("pop_to_empty_count", fifo_count, 3'd0);
        pop_main();
        check("pop_empty_ignored", fifo_count, 3'd0);

        // Glitch rejection
        tick();
        rx_a = 1'b0;
        repeat (4) tick();
        rx_a = 1'b1;
        repeat (30) tick();
        check("glitch_count", fifo_count, 3'd0);
        check("glitch_flags", {frame_err, parity_err, overrun}, 3'b000);

        // Framing error followed by a break, then a good byte
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0, 40, 1'b0, 1'b0);
        check("frame_err_set", frame_err, 1'b1);
        check("frame_err_no_push", fifo_count, 3'd0);
        send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        check("after_break_count", fifo_count, 3'd1);
        check("after_break_data", rd_data, 8'h11);
        check("frame_err_sticky", frame_err, 1'b1);
        pulse_clr();
        check("frame_err_cleared", frame_err, 1'b0);
        pop_main();

        // Even parity: 0x07 needs parity bit 1
        send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        check("parity_err_set", parity_err_p, 1'b1);
        check("parity_bad_no_push", fifo_count_p, 3'd0);
        pulse_clr();
        check("parity_err_cleared", parity_err_p, 1'b0);
        send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        check("parity_good_count", fifo_count_p, 3'd1);
        check("parity_good_data", rd_data_p, 8'h07);
        check("parity_good_flags", {frame_err_p, parity_err_p, overrun_p}, 3'b000);

        // Overrun with no reads
        for (int v = 1; v <= 5; v++) begin
            send_frame(0, 8'(v), 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        end
        check("overrun_set", overrun, 1'b1);
        check("overrun_count", fifo_count, 3'd4);
        for (int k = 1; k <= 4; k++) begin
            check("overrun_pop_data", rd_data, 32'(k));
            pop_main();
        end
        check("overrun_drained", rd_valid, 1'b0);

        // Full FIFO with pop on the push edge
        pulse_clr();
        check("overrun_cleared", overrun, 1'b0);
        for (int v = 16; v <= 19; v++) begin
            send_frame(0, 8'(v), 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        end
        check("full_count", fifo_count, 3'd4);
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1);
        check("simul_no_overrun", overrun, 1'b0);
        check("simul_count", fifo_count, 3'd4);
        check("simul_d0", rd_data, 8'h11);
        pop_main();
        check("simul_d1", rd_data, 8'h12);
        pop_main();
        check("simul_d2", rd_data, 8'h13);
        pop_main();
        check("simul_d3", rd_data, 8'h55);
        pop_main();
        check("simul_empty", fifo_count, 3'd0);

        // Receiver disabled
        rx_enable = 1'b0;
        send_frame(0, 8'h66, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        check("disabled_no_push", fifo_count, 3'd0);
        rx_enable = 1'b1;
        repeat (5) tick();

        // Reset mid-frame
        send_frame(0, 8'h42, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        check("pre_reset_frame_err", frame_err, 1'b1);
        send_frame(0, 8'h42, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        check("pre_reset_count", fifo_count, 3'd1);
        tick();
        rx_a = 1'b0;
        repeat (16) tick();
        rx_a = 1'b1;
        repeat (40) tick();
        reset = 1'b1;
        tick();
        tick();
        check("midreset_count", fifo_count, 3'd0);
        check("midreset_valid", rd_valid, 1'b0);
        check("midreset_data", rd_data, 8'h00);
        check("midreset_flags", {frame_err, parity_err, overrun}, 3'b000);
        reset = 1'b0;
        repeat (200) tick();
        check("no_partial_byte", fifo_count, 3'd0);
        send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        check("post_reset_count", fifo_count, 3'd1);
        check("post_reset_data", rd_data, 8'h5A);
        check("post_reset_flags", {frame_err, parity_err, overrun}, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
